// File: rtl/mips_decode_queue_if.sv
// Fetch-to-decode and decode-to-EX handshake bundle for mips_decode_queue.
// slave is the queue side, master is the fetch/EX side that drives it.
interface mips_decode_queue_if #(
  parameter int PC_WIDTH = 64
);
  logic                in_valid;
  logic                in_ready;
  logic [PC_WIDTH-1:0] in_pc;
  logic [31:0]         in_inst;
  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  logic [31:0]         out_inst;
  logic                out_ri;
  logic                out_writeenable;
  logic                out_rd_src;
  logic [1:0]          out_alu_src2;
  logic [1:0]          out_load_type;
  logic [1:0]          out_store_type;
  logic [1:0]          out_branch;
  logic [1:0]          out_jump;

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_ri, out_writeenable,
           out_rd_src, out_alu_src2, out_load_type, out_store_type,
           out_branch, out_jump
  );

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_ri, out_writeenable,
           out_rd_src, out_alu_src2, out_load_type, out_store_type,
           out_branch, out_jump
  );
endinterface

// File: rtl/mips_decode_queue.sv
// Instruction queue + MIPS decoder. Fetched {pc, inst} pairs are buffered in a
// DEPTH-entry FIFO; the head is decoded combinationally and captured into a
// registered control bundle offered to EX with valid/ready.
module mips_decode_queue #(
  parameter int DEPTH        = 4,
  parameter int PC_WIDTH     = 64,
  parameter bit ENABLE_64    = 1'b1,
  parameter int RI_CNT_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  mips_decode_queue_if.slave      bus,
  output logic [$clog2(DEPTH):0]  count,
  output logic [RI_CNT_WIDTH-1:0] ri_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // opcode / funct encodings (mips_define)
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J     = 6'h02, OP_BEQ   = 6'h04,
                         OP_BNE     = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09,
                         OP_SLTI    = 6'h0A, OP_SLTIU = 6'h0B, OP_ORI   = 6'h0D,
                         OP_XORI    = 6'h0E, OP_LUI   = 6'h0F, OP_DADDI = 6'h18,
                         OP_DADDIU  = 6'h19, OP_LB    = 6'h20, OP_LW    = 6'h23,
                         OP_LBU     = 6'h24, OP_LWU   = 6'h27, OP_SB    = 6'h28,
                         OP_SW      = 6'h2B, OP_BC    = 6'h32, OP_LD    = 6'h37,
                         OP_SD      = 6'h3F;
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR    = 6'h08,
                         FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB   = 6'h22,
                         FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR    = 6'h25,
                         FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT   = 6'h2A,
                         FN_SLTU = 6'h2B, FN_DADD = 6'h2C, FN_DADDU = 6'h2D,
                         FN_DSUB = 6'h2E, FN_DSLL = 6'h38, FN_DSRL  = 6'h3A,
                         FN_DSLL32 = 6'h3C, FN_DSRL32 = 6'h3E;

  typedef struct packed {
    logic       ri;
    logic       we;
    logic       rd_src;
    logic [1:0] alu_src2;
    logic [1:0] load_type;
    logic [1:0] store_type;
    logic [1:0] branch;
    logic [1:0] jump;
  } ctrl_t;

  logic [PC_WIDTH-1:0] pc_mem   [DEPTH];
  logic [31:0]         inst_mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic                push, load, dw;
  logic [31:0]         head_inst;
  logic [5:0]          op, fn;
  ctrl_t               dec, ctrl_q;

  // in_ready depends only on registered occupancy, never on out_ready
  assign bus.in_ready = (count != CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready && !flush;
  assign load         = (count != '0) && (!bus.out_valid || bus.out_ready) && !flush;
  assign head_inst    = inst_mem[rd_ptr];
  assign op           = head_inst[31:26];
  assign fn           = head_inst[5:0];

  // decode the FIFO head; doubleword ops collapse to RI when 64-bit is off
  always_comb begin
    dec = '0;
    dw  = 1'b0;
    if (head_inst != 32'h0) begin
      case (op)
        OP_SPECIAL: case (fn)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLL, FN_SRL:             dec.we = 1'b1;
          FN_DADD, FN_DADDU, FN_DSUB, FN_DSLL, FN_DSRL,
          FN_DSLL32, FN_DSRL32:                        begin dec.we = 1'b1; dw = 1'b1; end
          FN_JR:                                       dec.jump = 2'b10;
          default:                                     dec.ri = 1'b1;
        endcase
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
          dec.we = 1'b1; dec.rd_src = 1'b1; dec.alu_src2 = 2'b01;
        end
        OP_DADDI, OP_DADDIU: begin
          dec.we = 1'b1; dec.rd_src = 1'b1; dec.alu_src2 = 2'b01; dw = 1'b1;
        end
        OP_ORI, OP_XORI: begin
          dec.we = 1'b1; dec.rd_src = 1'b1; dec.alu_src2 = 2'b10;
        end
        OP_LUI: begin dec.we = 1'b1; dec.rd_src = 1'b1; end
        OP_LB, OP_LBU: begin
          dec.we = 1'b1; dec.rd_src = 1'b1; dec.alu_src2 = 2'b01; dec.load_type = 2'b01;
        end
        OP_LW: begin
          dec.we = 1'b1; dec.rd_src = 1'b1; dec.alu_src2 = 2'b01; dec.load_type = 2'b10;
        end
        OP_LWU: begin
          dec.we = 1'b1; dec.rd_src = 1'b1; dec.alu_src2 = 2'b01; dec.load_type = 2'b10;
          dw = 1'b1;
        end
        OP_LD: begin
          dec.we = 1'b1; dec.rd_src = 1'b1; dec.alu_src2 = 2'b01; dec.load_type = 2'b11;
          dw = 1'b1;
        end
        OP_SB:  begin dec.alu_src2 = 2'b01; dec.store_type = 2'b01; end
        OP_SW:  begin dec.alu_src2 = 2'b01; dec.store_type = 2'b10; end
        OP_SD:  begin dec.alu_src2 = 2'b01; dec.store_type = 2'b11; dw = 1'b1; end
        OP_BEQ: dec.branch = 2'b01;
        OP_BNE: dec.branch = 2'b10;
        OP_BC:  dec.branch = 2'b11;
        OP_J:   dec.jump   = 2'b01;
        default: dec.ri = 1'b1;
      endcase
      if (dw && !ENABLE_64) begin
        dec    = '0;
        dec.ri = 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset, pointers/count gate visibility
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr]   <= bus.in_pc;
      inst_mem[wr_ptr] <= bus.in_inst;
    end
  end

  // FIFO pointers and occupancy; flush empties the queue
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(load);
    end
  end

  // output bundle register: load on pop, hold while stalled
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_pc    <= '0;
      bus.out_inst  <= '0;
      ctrl_q        <= '0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_pc    <= pc_mem[rd_ptr];
      bus.out_inst  <= head_inst;
      ctrl_q        <= dec;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // saturating count of RI bundles accepted by EX; only reset clears it
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      ri_count <= '0;
    else if (bus.out_valid && bus.out_ready && ctrl_q.ri && (ri_count != '1))
      ri_count <= ri_count + RI_CNT_WIDTH'(1);
  end

  assign bus.out_ri          = ctrl_q.ri;
  assign bus.out_writeenable = ctrl_q.we;
  assign bus.out_rd_src      = ctrl_q.rd_src;
  assign bus.out_alu_src2    = ctrl_q.alu_src2;
  assign bus.out_load_type   = ctrl_q.load_type;
  assign bus.out_store_type  = ctrl_q.store_type;
  assign bus.out_branch      = ctrl_q.branch;
  assign bus.out_jump        = ctrl_q.jump;
endmodule

// File: tb/tb_mips_decode_queue.sv
// Bench for mips_decode_queue: random traffic on a 64-bit instance against a
// queue-based reference model, plus directed cases on a 32-bit-only instance.
module tb_mips_decode_queue;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        flush_b = 1'b0;
  logic [2:0]  cnt_a, cnt_b;
  logic [15:0] ric_a, ric_b;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  mips_decode_queue_if #(.PC_WIDTH(64)) a_if ();
  mips_decode_queue_if #(.PC_WIDTH(64)) b_if ();

  mips_decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(64), .ENABLE_64(1'b1), .RI_CNT_WIDTH(16)) dut_a (
    .clock(clock), .reset(reset), .flush(flush), .bus(a_if), .count(cnt_a), .ri_count(ric_a));
  mips_decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(64), .ENABLE_64(1'b0), .RI_CNT_WIDTH(16)) dut_b (
    .clock(clock), .reset(reset), .flush(flush_b), .bus(b_if), .count(cnt_b), .ri_count(ric_b));

  // ---------------- reference model ----------------
  typedef enum {M_RI, M_NOP, M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR,
                M_SLT, M_SLTU, M_SLL, M_SRL, M_JR, M_ADDI, M_ADDIU, M_SLTI, M_SLTIU,
                M_ORI, M_XORI, M_LUI, M_LB, M_LBU, M_LW, M_SB, M_SW, M_BEQ, M_BNE,
                M_BC, M_J, M_DADD, M_DADDU, M_DSUB, M_DSLL, M_DSRL, M_DSLL32, M_DSRL32,
                M_DADDI, M_DADDIU, M_LD, M_LWU, M_SD} mn_t;

  // name the instruction from the ISA tables
  function automatic mn_t mnem(logic [31:0] i, bit e64);
    mn_t m;
    m = M_RI;
    if (i == 32'h0) return M_NOP;
    case (i[31:26])
      6'h00: case (i[5:0])
        6'h20: m = M_ADD;  6'h21: m = M_ADDU; 6'h22: m = M_SUB;  6'h23: m = M_SUBU;
        6'h24: m = M_AND;  6'h25: m = M_OR;   6'h26: m = M_XOR;  6'h27: m = M_NOR;
        6'h2A: m = M_SLT;  6'h2B: m = M_SLTU; 6'h00: m = M_SLL;  6'h02: m = M_SRL;
        6'h08: m = M_JR;   6'h2C: m = M_DADD; 6'h2D: m = M_DADDU; 6'h2E: m = M_DSUB;
        6'h38: m = M_DSLL; 6'h3A: m = M_DSRL; 6'h3C: m = M_DSLL32; 6'h3E: m = M_DSRL32;
        default: m = M_RI;
      endcase
      6'h08: m = M_ADDI; 6'h09: m = M_ADDIU; 6'h0A: m = M_SLTI; 6'h0B: m = M_SLTIU;
      6'h0D: m = M_ORI;  6'h0E: m = M_XORI;  6'h0F: m = M_LUI;  6'h20: m = M_LB;
      6'h24: m = M_LBU;  6'h23: m = M_LW;    6'h28: m = M_SB;   6'h2B: m = M_SW;
      6'h04: m = M_BEQ;  6'h05: m = M_BNE;   6'h32: m = M_BC;   6'h02: m = M_J;
      6'h18: m = M_DADDI; 6'h19: m = M_DADDIU; 6'h37: m = M_LD; 6'h27: m = M_LWU;
      6'h3F: m = M_SD;
      default: m = M_RI;
    endcase
    if (!e64 && (m inside {M_DADD, M_DADDU, M_DSUB, M_DSLL, M_DSRL, M_DSLL32, M_DSRL32,
                           M_DADDI, M_DADDIU, M_LD, M_LWU, M_SD}))
      m = M_RI;
    return m;
  endfunction

  // control bundle {ri,we,rd_src,alu2,load,store,branch,jump} from category rules
  function automatic logic [12:0] ctrl_of(logic [31:0] i, bit e64);
    mn_t m;
    bit reg_op, imm_op, ld_op, st_op, ri, we, rd;
    logic [1:0] alu2, ldt, stt, br, jp;
    m      = mnem(i, e64);
    reg_op = m inside {M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT,
                       M_SLTU, M_SLL, M_SRL, M_DADD, M_DADDU, M_DSUB, M_DSLL, M_DSRL,
                       M_DSLL32, M_DSRL32};
    imm_op = m inside {M_ADDI, M_ADDIU, M_SLTI, M_SLTIU, M_ORI, M_XORI, M_DADDI, M_DADDIU};
    ld_op  = m inside {M_LB, M_LBU, M_LW, M_LWU, M_LD};
    st_op  = m inside {M_SB, M_SW, M_SD};
    ri     = (m == M_RI);
    we     = reg_op || imm_op || ld_op || (m == M_LUI);
    rd     = imm_op || ld_op || (m == M_LUI);
    alu2   = (m inside {M_ORI, M_XORI}) ? 2'b10 : (imm_op || ld_op || st_op) ? 2'b01 : 2'b00;
    ldt    = (m inside {M_LB, M_LBU}) ? 2'd1 : (m inside {M_LW, M_LWU}) ? 2'd2 : (m == M_LD) ? 2'd3 : 2'd0;
    stt    = (m == M_SB) ? 2'd1 : (m == M_SW) ? 2'd2 : (m == M_SD) ? 2'd3 : 2'd0;
    br     = (m == M_BEQ) ? 2'd1 : (m == M_BNE) ? 2'd2 : (m == M_BC) ? 2'd3 : 2'd0;
    jp     = (m == M_J) ? 2'd1 : (m == M_JR) ? 2'd2 : 2'd0;
    return {ri, we, rd, alu2, ldt, stt, br, jp};
  endfunction

  typedef struct packed { logic [63:0] pc; logic [31:0] inst; } ent_t;
  ent_t q[$];
  bit   m_ov = 1'b0;
  ent_t m_out;
  int   m_ric = 0;

  logic [5:0] r_fn [20] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                            6'h00, 6'h02, 6'h08, 6'h2C, 6'h2D, 6'h2E, 6'h38, 6'h3A, 6'h3C, 6'h3E};
  logic [5:0] i_op [22] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h24, 6'h23,
                            6'h28, 6'h2B, 6'h04, 6'h05, 6'h32, 6'h02, 6'h18, 6'h19, 6'h37, 6'h27,
                            6'h3F, 6'h3B};

  function automatic logic [31:0] rand_inst();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel <= 2) return {6'h00, 20'($urandom), r_fn[$urandom_range(0, 19)]};
    if (sel <= 6) return {i_op[$urandom_range(0, 21)], 26'($urandom)};
    if (sel == 7) return 32'h0;
    return 32'($urandom);
  endfunction

  function automatic logic [12:0] dut_ctrl_a();
    return {a_if.out_ri, a_if.out_writeenable, a_if.out_rd_src, a_if.out_alu_src2,
            a_if.out_load_type, a_if.out_store_type, a_if.out_branch, a_if.out_jump};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // one clock on instance A: advance the model with the driven inputs, then compare
  task automatic step();
    bit do_load, do_push;
    @(posedge clock);
    if (m_ov && a_if.out_ready && ctrl_of(m_out.inst, 1'b1)[12] && m_ric != 65535) m_ric++;
    if (flush) begin
      q.delete();
      m_ov = 1'b0;
    end else begin
      do_load = (q.size() != 0) && (!m_ov || a_if.out_ready);
      do_push = a_if.in_valid && (q.size() != DEPTH);
      if (do_load) begin
        m_out = q.pop_front();
        m_ov  = 1'b1;
      end else if (m_ov && a_if.out_ready) m_ov = 1'b0;
      if (do_push) q.push_back({a_if.in_pc, a_if.in_inst});
    end
    #1;
    chk("out_valid", a_if.out_valid, m_ov);
    chk("in_ready", a_if.in_ready, q.size() != DEPTH);
    chk("count", cnt_a, q.size());
    chk("ri_count", ric_a, m_ric);
    if (m_ov) begin
      chk("out_pc", a_if.out_pc, m_out.pc);
      chk("out_inst", a_if.out_inst, m_out.inst);
      chk("ctrl", dut_ctrl_a(), ctrl_of(m_out.inst, 1'b1));
    end
    @(negedge clock);
  endtask

  task automatic drive_a(bit v, logic [63:0] pc, logic [31:0] inst);
    a_if.in_valid = v;
    a_if.in_pc    = pc;
    a_if.in_inst  = inst;
  endtask

  initial begin
    int n_acc;
    int exp_b;
    int bias;
    drive_a(1'b0, 64'h0, 32'h0);
    a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_pc = 64'h0; b_if.in_inst = 32'h0; b_if.out_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_out_valid", a_if.out_valid, 0);
    chk("rst_in_ready", a_if.in_ready, 1);
    chk("rst_count", cnt_a, 0);
    chk("rst_ri_count", ric_a, 0);
    chk("rst_bundle", {a_if.out_pc, dut_ctrl_a()}, 0);
    reset = 1'b0;

    // addu into an empty queue: valid after the second edge
    a_if.out_ready = 1'b1;
    drive_a(1'b1, 64'h100, 32'h00851021);
    step();
    drive_a(1'b0, 64'h0, 32'h0);
    chk("addu_edge1_valid", a_if.out_valid, 0);
    step();
    chk("addu_valid", a_if.out_valid, 1);
    chk("addu_pc", a_if.out_pc, 64'h100);
    chk("addu_we_rd_alu", {a_if.out_writeenable, a_if.out_rd_src, a_if.out_alu_src2}, 4'b1000);
    step();

    // five pushes with EX stalled: output holds first, queue full
    a_if.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_a(1'b1, 64'h200 + 64'(4 * k), rand_inst());
      step();
    end
    chk("full_count", cnt_a, 4);
    chk("full_in_ready", a_if.in_ready, 0);
    chk("full_head_pc", a_if.out_pc, 64'h200);
    drive_a(1'b1, 64'h999, 32'h00851021);
    step();
    drive_a(1'b0, 64'h0, 32'h0);
    step();
    chk("stall_hold_pc", a_if.out_pc, 64'h200);
    a_if.out_ready = 1'b1;
    repeat (6) step();

    // ld with doubleword ops enabled
    drive_a(1'b1, 64'h300, 32'hDC820008);
    step();
    drive_a(1'b0, 64'h0, 32'h0);
    step();
    chk("ld64_ri", a_if.out_ri, 0);
    chk("ld64_load_type", a_if.out_load_type, 2'b11);
    chk("ld64_rd_src", a_if.out_rd_src, 1);
    step();

    // flush with three queued entries and a valid output
    a_if.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_a(1'b1, 64'h400 + 64'(4 * k), rand_inst());
      step();
    end
    chk("preflush_count", cnt_a, 3);
    flush = 1'b1;
    drive_a(1'b1, 64'h500, 32'h00851021);
    step();
    chk("flush_count", cnt_a, 0);
    chk("flush_out_valid", a_if.out_valid, 0);
    chk("flush_in_ready", a_if.in_ready, 1);
    flush = 1'b0;
    drive_a(1'b0, 64'h0, 32'h0);
    a_if.out_ready = 1'b1;
    step();
    step();
    chk("flush_dropped", a_if.out_valid, 0);

    // random traffic with shifting back-pressure
    bias = 3;
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) bias = $urandom_range(0, 3);
      drive_a($urandom_range(0, 3) != 0, {$urandom, $urandom}, rand_inst());
      a_if.out_ready = ($urandom_range(0, 3) < bias) || (bias == 3);
      flush = ($urandom_range(0, 39) == 0);
      step();
    end
    flush = 1'b0;

    // make sure an RI handshake has been counted, then fill and reset between edges
    a_if.out_ready = 1'b1;
    drive_a(1'b1, 64'h600, 32'hEC000000);
    step();
    drive_a(1'b0, 64'h0, 32'h0);
    repeat (3) step();
    a_if.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_a(1'b1, 64'h700 + 64'(4 * k), 32'hEC000000);
      step();
    end
    drive_a(1'b0, 64'h0, 32'h0);
    chk("prereset_count", cnt_a, 4);
    chk("prereset_ri_nonzero", ric_a != 16'h0, 1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_out_valid", a_if.out_valid, 0);
    chk("async_count", cnt_a, 0);
    chk("async_ri_count", ric_a, 0);
    chk("async_in_ready", a_if.in_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    q.delete(); m_ov = 1'b0; m_ric = 0;

    // 32-bit-only instance: ld decodes as reserved
    b_if.out_ready = 1'b1;
    b_if.in_valid  = 1'b1;
    b_if.in_pc     = 64'h200;
    b_if.in_inst   = 32'hDC820008;
    @(posedge clock); @(negedge clock);
    b_if.in_valid = 1'b0;
    chk("ld32_edge1_valid", b_if.out_valid, 0);
    @(posedge clock); @(negedge clock);
    chk("ld32_valid", b_if.out_valid, 1);
    chk("ld32_ri", b_if.out_ri, 1);
    chk("ld32_load_type", b_if.out_load_type, 0);
    chk("ld32_we", b_if.out_writeenable, 0);
    chk("ld32_pc", b_if.out_pc, 64'h200);
    chk("ld32_ri_count0", ric_b, 0);
    @(posedge clock); @(negedge clock);
    chk("ld32_ri_count1", ric_b, 1);

    // drive ri_count to 0xFFFE, then three more to hit saturation
    n_acc = 0;
    b_if.in_valid = 1'b1;
    for (int k = 0; k < 65533; k++) begin
      if (b_if.in_ready) n_acc++;
      @(posedge clock); @(negedge clock);
    end
    b_if.in_valid = 1'b0;
    repeat (4) begin @(posedge clock); @(negedge clock); end
    exp_b = (1 + n_acc > 65535) ? 65535 : 1 + n_acc;
    chk("ri_cnt_fffe", ric_b, exp_b);
    b_if.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (b_if.in_ready) n_acc++;
      @(posedge clock); @(negedge clock);
    end
    b_if.in_valid = 1'b0;
    repeat (4) begin @(posedge clock); @(negedge clock); end
    exp_b = (1 + n_acc > 65535) ? 65535 : 1 + n_acc;
    chk("ri_cnt_sat", ric_b, exp_b);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
